// File: rtl/riscv_div_unit_pkg.sv
// Shared constants for the RV32M divide unit: func codes, FSM state type and decode helper.
package riscv_div_unit_pkg;

    localparam int unsigned DATA_SIZE  = 32;
    localparam int unsigned DIV_CYCLES = 32;

    localparam logic [2:0] DIV_FUNC  = 3'h4;
    localparam logic [2:0] DIVU_FUNC = 3'h5;
    localparam logic [2:0] REM_FUNC  = 3'h6;
    localparam logic [2:0] REMU_FUNC = 3'h7;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state;

    function automatic logic is_div_func(input logic [2:0] func);
        return func[2];
    endfunction

endpackage

// File: rtl/riscv_div_unit.sv
// Multicycle radix-2 restoring divider for div/divu/rem/remu.
// Divide-by-zero and signed overflow are resolved in the acceptance cycle.
module riscv_div_unit
    import riscv_div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_SIZE,
    parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        func,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    div_state          state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [2:0]        func_q, func_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic              is_signed;
    logic              sa, sb;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic [DATA_W:0]   shifted, trial;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    always_comb begin
        is_signed = ~func[0];
        sa        = is_signed & op_a[DATA_W-1];
        sb        = is_signed & op_b[DATA_W-1];
        abs_a     = sa ? (~op_a + 1'b1) : op_a;
        abs_b     = sb ? (~op_b + 1'b1) : op_b;
        // Partial remainder stays below the divisor, so the trial difference fits DATA_W bits.
        shifted   = {rem_q, quo_q[DATA_W-1]};
        trial     = shifted - {1'b0, dvs_q};
        quo_fix   = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
        rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        func_d    = func_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        unique case (state_q)
            IDLE: begin
                if (start && is_div_func(func)) begin
                    func_d    = func;
                    neg_quo_d = sa ^ sb;
                    neg_rem_d = sa;
                    if (op_b == '0) begin
                        result_d = func[1] ? op_a : '1;
                        state_d  = DONE;
                    end else if (is_signed && op_a == INT_MIN && op_b == '1) begin
                        result_d = func[1] ? '0 : INT_MIN;
                        state_d  = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        cnt_d   = CNT_W'(DATA_W);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[DATA_W]) begin
                    rem_d = trial[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d = func_q[1] ? rem_fix : quo_fix;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A killed operation must not disturb the visible result.
        if (flush) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            func_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            func_q    <= func_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed bench for riscv_div_unit: latency, signed/unsigned results, corner cases, flush, reset.
module tb_riscv_div_unit;
    import riscv_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func = 3'h0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    riscv_div_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .func   (func),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation and checks latency, busy ready, result and the return to idle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int   cyc;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; func = f; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (ready) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (ready) busy_ok = 1'b0;
        check({tag, " latency"}, 34'(cyc), 34'(exp_cyc));
        check({tag, " result"}, {2'b0, result}, {2'b0, exp});
        check({tag, " busy"}, {33'b0, busy_ok}, 34'd1);
        @(posedge clk); #1;
        check({tag, " idle"}, {32'b0, ready, done}, 34'b10);
        check({tag, " hold"}, {2'b0, result}, {2'b0, exp});
    endtask

    task automatic count_done(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
    endtask

    initial begin
        int seen;

        #1;
        check("reset state", {ready, done, result}, {1'b1, 1'b0, 32'h0});
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div 100/7", DIV_FUNC, 32'd100, 32'd7, 32'd14, 34);
        run_op("rem 100/7", REM_FUNC, 32'd100, 32'd7, 32'd2, 34);
        run_op("div -7/2", DIV_FUNC, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem -7/2", REM_FUNC, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("remu", REMU_FUNC, 32'hFFFF_FFF9, 32'd2, 32'd1, 34);
        run_op("divu", DIVU_FUNC, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);
        run_op("div 7/-2", DIV_FUNC, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("rem 7/-2", REM_FUNC, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        run_op("divu by 0", DIVU_FUNC, 32'd123, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem by 0", REM_FUNC, 32'd123, 32'd0, 32'd123, 1);
        run_op("div ovf", DIV_FUNC, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf", REM_FUNC, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("divu no ovf", DIVU_FUNC, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run_op("remu no ovf", REMU_FUNC, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);

        // Start while busy must not disturb the running operation.
        @(negedge clk);
        start = 1'b1; func = DIV_FUNC; op_a = 32'd50; op_b = 32'd5;
        @(posedge clk); #1;
        op_a = 32'd99; op_b = 32'd1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
        end
        check("busy start ignored", {2'b0, result}, {2'b0, 32'd10});
        @(posedge clk); #1;

        // Flush mid-calculation.
        @(negedge clk);
        start = 1'b1; func = DIV_FUNC; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush idle", {32'b0, ready, done}, 34'b10);
        run_op("div 9/3 after flush", DIV_FUNC, 32'd9, 32'd3, 32'd3, 34);

        // Flush coincident with start drops the start.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; func = DIV_FUNC; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush+start ready", {33'b0, ready}, 34'd1);
        count_done(40, seen);
        check("flush+start no done", 34'(seen), 34'd0);

        // Reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; func = DIV_FUNC; op_a = 32'd1000; op_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid reset", {ready, done, result}, {1'b1, 1'b0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, seen);
        check("no done after reset", 34'(seen), 34'd0);

        // Non-divide func is ignored.
        @(negedge clk);
        start = 1'b1; func = 3'h0; op_a = 32'd10; op_b = 32'd2;
        @(posedge clk); #1;
        check("func0 ready", {33'b0, ready}, 34'd1);
        start = 1'b0;
        count_done(10, seen);
        check("func0 no done", {32'(seen), ready, 1'b0}, {32'd0, 1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
